// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache and its miss handler.
// Holds the miss-handler state encoding, the default geometry and the
// address-field widths derived from it, plus a block-alignment helper.
package dcache_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned BLOCK_SIZE_D = 128;
  localparam int unsigned NUM_ENTS_D   = 64;

  localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE_D / 8);
  localparam int unsigned INDEX_W  = $clog2(NUM_ENTS_D);
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    FILL_REQ,
    FILL_WAIT,
    REPAIR,
    WB_REQ,
    DONE
  } miss_state_t;

  // Clear the byte-offset bits so the address points at the start of a block.
  function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned   off_w);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the miss-handler statistics.
// Ports: clk, rst (async active-low clear), inc (count this cycle),
//        count (current value; holds at all-ones).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_miss_handler.sv
// Miss/refill engine between the direct-mapped data cache and main memory.
// Accepts one miss at a time, reads the missing block, merges store data on a
// write miss, repairs the cache line and writes back a dirty victim if the
// cache reports one. The load/store stage replays after miss_done_o.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   miss_*                   miss request from load/store stage, done pulse
//   mem_req_*, mem_resp_*    block read/write interface to memory
//   cache_*                  repair write into the cache
//   wb_evicted_*             dirty victim reported by the cache during repair
//   stat_misses_o/stat_wbs_o saturating statistics counters
module dcache_miss_handler
  import dcache_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 128,
  parameter int unsigned NUM_ENTS   = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_addr_i,
  input  logic                  miss_is_wr_i,
  input  logic [31:0]           miss_wdata_i,
  output logic                  miss_done_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [BLOCK_SIZE-1:0] mem_req_wdata_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BLOCK_SIZE-1:0] mem_resp_data_i,
  output logic                  cache_wr_en_o,
  output logic                  cache_is_repair_o,
  output logic [31:0]           cache_wr_addr_o,
  output logic [BLOCK_SIZE-1:0] cache_repair_data_o,
  output logic                  cache_repair_dirty_o,
  input  logic                  wb_evicted_en_i,
  input  logic [BLOCK_SIZE-1:0] wb_evicted_block_i,
  input  logic [31:0]           wb_evicted_addr_i,
  output logic [CNT_W-1:0]      stat_misses_o,
  output logic [CNT_W-1:0]      stat_wbs_o
);

  localparam int unsigned OFF_W = $clog2(BLOCK_SIZE / 8);
  localparam int unsigned IDX_W = $clog2(NUM_ENTS);

  if ((BLOCK_SIZE < 32) || ((BLOCK_SIZE % 32) != 0) || (NUM_ENTS < 1) ||
      ((OFF_W + IDX_W) >= 32)) begin : g_bad_cfg
    $error("dcache_miss_handler: unsupported BLOCK_SIZE/NUM_ENTS");
  end

  miss_state_t state_q, state_d;

  logic [31:0]           lat_addr;
  logic                  lat_is_wr;
  logic [31:0]           lat_wdata;
  logic [BLOCK_SIZE-1:0] lat_block;
  logic [31:0]           vic_addr;
  logic [BLOCK_SIZE-1:0] vic_block;
  logic [BLOCK_SIZE-1:0] merged;
  int unsigned           word_idx;

  logic miss_accept;
  logic wb_accept;

  assign miss_accept = (state_q == IDLE) && miss_valid_i;
  assign wb_accept   = (state_q == WB_REQ) && mem_req_ready_i;

  // Word select taken from the byte offset shifted down by 2; written as a
  // shift so a single-word block (zero-width select) needs no special case.
  always_comb begin
    word_idx = 32'(lat_addr[OFF_W-1:0]) >> 2;
    merged   = mem_resp_data_i;
    if (lat_is_wr) begin
      merged[32*word_idx +: 32] = lat_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss_valid_i)     state_d = FILL_REQ;
      FILL_REQ:  if (mem_req_ready_i)  state_d = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid_i) state_d = REPAIR;
      REPAIR:    state_d = wb_evicted_en_i ? WB_REQ : DONE;
      WB_REQ:    if (mem_req_ready_i)  state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_is_wr <= 1'b0;
      lat_wdata <= '0;
      lat_block <= '0;
      vic_addr  <= '0;
      vic_block <= '0;
    end else begin
      if (miss_accept) begin
        lat_addr  <= miss_addr_i;
        lat_is_wr <= miss_is_wr_i;
        lat_wdata <= miss_wdata_i;
      end
      if ((state_q == FILL_WAIT) && mem_resp_valid_i) begin
        lat_block <= merged;
      end
      if ((state_q == REPAIR) && wb_evicted_en_i) begin
        vic_addr  <= wb_evicted_addr_i;
        vic_block <= wb_evicted_block_i;
      end
    end
  end

  // Outputs decode only the state register and latched data, so nothing on
  // the memory input side reaches the memory request outputs combinationally.
  always_comb begin
    miss_ready_o         = 1'b0;
    miss_done_o          = 1'b0;
    mem_req_valid_o      = 1'b0;
    mem_req_we_o         = 1'b0;
    mem_req_addr_o       = '0;
    mem_req_wdata_o      = '0;
    cache_wr_en_o        = 1'b0;
    cache_is_repair_o    = 1'b0;
    cache_wr_addr_o      = '0;
    cache_repair_data_o  = '0;
    cache_repair_dirty_o = 1'b0;
    unique case (state_q)
      IDLE: miss_ready_o = 1'b1;
      FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = block_align(lat_addr, OFF_W);
      end
      REPAIR: begin
        cache_wr_en_o        = 1'b1;
        cache_is_repair_o    = 1'b1;
        cache_wr_addr_o      = lat_addr;
        cache_repair_data_o  = lat_block;
        cache_repair_dirty_o = lat_is_wr;
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = block_align(vic_addr, OFF_W);
        mem_req_wdata_o = vic_block;
      end
      DONE: miss_done_o = 1'b1;
      default: ;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stat_misses (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_accept),
    .count (stat_misses_o)
  );

  sat_counter #(.W(CNT_W)) u_stat_wbs (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_accept),
    .count (stat_wbs_o)
  );

endmodule

// File: doc/dcache_miss_handler.md
Name: dcache_miss_handler

Overview:
- Miss/refill engine sitting between the direct-mapped data cache and main memory.
- Accepts one cache miss at a time from the load/store stage and fetches the missing block from memory.
- Repairs the cache line, merging store data on a write miss, then writes back any dirty victim the cache evicts.
- Single outstanding transaction; the load/store stage replays its access after the done pulse.

Parameters:
BLOCK_SIZE, 128, cache block width in bits; multiple of 32, at least 32.
NUM_ENTS, 64, number of cache lines; must match the cache instance.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
miss_valid_i  in  1  load/store stage presents a miss
miss_ready_o  out  1  handler idle and able to accept a miss
miss_addr_i  in  32  byte address of the missing access
miss_is_wr_i  in  1  the miss is a store
miss_wdata_i  in  32  store word for a write miss
miss_done_o  out  1  one-cycle pulse: line repaired, access may replay
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts the request this cycle
mem_req_we_o  out  1  1 = block write (writeback), 0 = block read (fill)
mem_req_addr_o  out  32  block-aligned address; low log2(BLOCK_SIZE/8) bits are 0
mem_req_wdata_o  out  BLOCK_SIZE  writeback data
mem_resp_valid_i  in  1  fill data valid; arrives only for reads
mem_resp_data_i  in  BLOCK_SIZE  fill data
cache_wr_en_o  out  1  cache write enable
cache_is_repair_o  out  1  the cache write is a repair
cache_wr_addr_o  out  32  repair address, equal to the latched miss address
cache_repair_data_o  out  BLOCK_SIZE  repaired block
cache_repair_dirty_o  out  1  mark the repaired line dirty
wb_evicted_en_i  in  1  cache reports a dirty victim, valid in the repair cycle
wb_evicted_block_i  in  BLOCK_SIZE  victim data
wb_evicted_addr_i  in  32  victim block address, driven by the cache from the stored tag and the index
stat_misses_o  out  CNT_W  count of accepted misses; saturating
stat_wbs_o  out  CNT_W  count of issued writebacks; saturating

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except miss_ready_o=1. Latched address, data and victim registers cleared. Counters cleared.
- An in-flight memory transaction is abandoned on reset; the memory side must tolerate this.
- IDLE: miss_ready_o=1. On miss_valid_i&&miss_ready_o, latch addr, is_wr and wdata, increment stat_misses, go to FILL_REQ.
- FILL_REQ: mem_req_valid_o=1, we=0, addr = block-aligned latched address. Outputs stay stable until mem_req_ready_i, then go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid_i, latch the fill block.
  - If is_wr, overwrite 32-bit word [offset*32 +: 32] with wdata; offset = addr[log2(BLOCK_SIZE/32)+1:2].
  - Go to REPAIR.
  - mem_resp_valid_i in any other state is ignored.
- REPAIR (exactly 1 cycle): cache_wr_en_o=1, cache_is_repair_o=1, cache_wr_addr_o = latched address, cache_repair_data_o = merged block, cache_repair_dirty_o = is_wr.
  - Sample wb_evicted_en_i in the same cycle.
  - If 1: latch block and address, go to WB_REQ.
  - Else: go to DONE.
- WB_REQ: mem_req_valid_o=1, we=1, addr = victim address, wdata = victim block; stable until ready. On mem_req_ready_i, increment stat_wbs and go to DONE. Writes are posted; no response is expected.
- DONE: miss_done_o=1 for one cycle, then go to IDLE. miss_ready_o rises the cycle after DONE.
- Fill-before-writeback ordering is safe: the victim and the new block differ in tag, so their addresses never alias.
- miss_ready_o=0 in every state except IDLE; miss_valid_i is ignored while busy.
- Cache outputs are 0 outside REPAIR. mem_req_* outputs are 0 outside FILL_REQ and WB_REQ.
- Counters hold at 2^CNT_W-1.
- All outputs are registered state decodes. There is no combinational path from memory inputs to memory outputs.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, FILL_REQ, FILL_WAIT, REPAIR, WB_REQ, DONE};
  - localparams for offset/index/tag widths derived from BLOCK_SIZE and NUM_ENTS, shared with the cache.
- Sub-module sat_counter #(W) is instantiated twice for the statistics counters.
- FSM, latches and merge logic live in this module.

Test Plan:
- Read miss, clean victim. Setup: addr 0x0000_1234; mem ready at once; fill response 3 cycles later with 0xDDDD_CCCC_BBBB_AAAA_... Checks:
  - mem read to 0x0000_1230;
  - repair data equals the fill, dirty=0;
  - no writeback, done pulse, stat_misses=1.
- Write miss, merge. Setup: addr 0x0000_1238, wdata 0xCAFEF00D. Check: repair block word 2 = 0xCAFEF00D, other words equal the fill, dirty=1.
- Dirty victim. Setup: wb_evicted_en_i=1 in the REPAIR cycle, victim addr 0x0004_1230. Checks:
  - mem write to 0x0004_1230 follows the fill, with the victim data;
  - stat_wbs=1;
  - done only after the write handshake.
- Backpressure. Setup: mem_req_ready_i low for 5 cycles in FILL_REQ and WB_REQ. Check: request outputs are stable throughout, exactly one handshake each.
- Busy/stray inputs. Setup: miss_valid_i held during a fill; stray mem_resp_valid_i in IDLE. Checks:
  - miss_ready_o=0 while busy;
  - stray response ignored;
  - the second miss is accepted only after DONE.
- Async reset mid-FILL_WAIT. Setup: rst low asynchronously. Checks:
  - immediately IDLE, mem_req_valid_o=0, counters 0;
  - a new miss after release completes normally.
